// File: rtl/prbs_axis_src.sv
// Framed PRBS test-pattern generator with an AXI4-Stream master port.
// A run is armed by a start pulse. It emits num_frames frames of frame_len
// beats each, or runs continuously until stop when num_frames is 0. The LFSR
// sequence continues across beats and frames for the whole run.
module prbs_axis_src #(
    parameter int AXIS_BYTES = 8,
    parameter int LEN_W      = 16,
    parameter int CNT_W      = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    stop,
    input  logic [1:0]              poly_sel,
    input  logic [30:0]             seed,
    input  logic [LEN_W-1:0]        frame_len,
    input  logic [CNT_W-1:0]        num_frames,
    output logic                    busy,
    output logic                    done,
    output logic [CNT_W-1:0]        frames_sent,
    output logic [AXIS_BYTES*8-1:0] m_axis_tdata,
    output logic [AXIS_BYTES-1:0]   m_axis_tkeep,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast
);

    localparam int DW = AXIS_BYTES * 8;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t            state_q, state_d;
    logic [1:0]        poly_q;
    logic [LEN_W-1:0]  len_q;
    logic [CNT_W-1:0]  nfr_q;
    logic [30:0]       lfsr_q;
    logic [DW-1:0]     data_q;
    logic              last_q;
    logic [LEN_W-1:0]  beat_cnt_q;
    logic [CNT_W-1:0]  frames_q;
    logic              stop_pend_q;
    logic              done_q;

    // Mask of the register bits that belong to the selected polynomial.
    function automatic logic [30:0] poly_mask(input logic [1:0] poly);
        case (poly)
            2'd0:    return 31'h0000_007F;
            2'd1:    return 31'h0000_7FFF;
            2'd2:    return 31'h007F_FFFF;
            default: return 31'h7FFF_FFFF;
        endcase
    endfunction

    // Seed with the unused bits dropped; an all-zero seed would lock the LFSR,
    // so it is replaced by all ones.
    function automatic logic [30:0] seed_init(input logic [30:0] sd, input logic [1:0] poly);
        logic [30:0] m;
        m = poly_mask(poly);
        if ((sd & m) == '0) return m;
        return sd & m;
    endfunction

    // Runs DW Fibonacci steps. The first generated bit lands in data bit 0.
    // Returns {post-beat LFSR state, beat data}.
    function automatic logic [DW+30:0] gen_beat(input logic [30:0] s_in, input logic [1:0] poly);
        logic [30:0]   s;
        logic [DW-1:0] d;
        logic          b;
        s = s_in;
        d = '0;
        for (int i = 0; i < DW; i++) begin
            case (poly)
                2'd0:    b = s[6]  ^ s[5];
                2'd1:    b = s[14] ^ s[13];
                2'd2:    b = s[22] ^ s[17];
                default: b = s[30] ^ s[27];
            endcase
            d[i] = b;
            s    = {s[29:0], b};
        end
        return {s & poly_mask(poly), d};
    endfunction

    logic [DW+30:0] seed_beat;
    logic [DW+30:0] next_beat;
    logic           start_ok;
    logic           hs;
    logic           frame_end;
    logic           run_end;

    assign seed_beat = gen_beat(seed_init(seed, poly_sel), poly_sel);
    assign next_beat = gen_beat(lfsr_q, poly_q);
    assign start_ok  = (state_q == S_IDLE) && start && (frame_len != '0);
    assign hs        = (state_q == S_RUN) && m_axis_tready;
    assign frame_end = hs && last_q;
    // The run ends on a frame boundary: either the frame quota is reached or a
    // stop is pending. A stop that arrives with the final tlast still counts.
    assign run_end   = frame_end &&
                       (((nfr_q != '0) && (frames_q + CNT_W'(1) == nfr_q)) ||
                        stop_pend_q || stop);

    // State register.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    // NOTE: state_d is given a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start_ok) state_d = S_RUN;
            S_RUN:  if (run_end)  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs; the stream is gated so that everything reads 0 outside RUN.
    always_comb begin
        busy          = (state_q == S_RUN);
        m_axis_tvalid = busy;
        m_axis_tdata  = busy ? data_q : '0;
        m_axis_tkeep  = busy ? '1 : '0;
        m_axis_tlast  = busy && last_q;
        done          = done_q;
        frames_sent   = frames_q;
    end

    // Run configuration, LFSR, beat/frame counters and the done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            poly_q      <= '0;
            len_q       <= '0;
            nfr_q       <= '0;
            lfsr_q      <= '0;
            data_q      <= '0;
            last_q      <= 1'b0;
            beat_cnt_q  <= '0;
            frames_q    <= '0;
            stop_pend_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= run_end;
            if (start_ok) begin
                poly_q      <= poly_sel;
                len_q       <= frame_len;
                nfr_q       <= num_frames;
                lfsr_q      <= seed_beat[DW+30:DW];
                data_q      <= seed_beat[DW-1:0];
                last_q      <= (frame_len == LEN_W'(1));
                beat_cnt_q  <= '0;
                frames_q    <= '0;
                stop_pend_q <= 1'b0;
            end else if (state_q == S_RUN) begin
                if (stop) stop_pend_q <= 1'b1;
                if (hs) begin
                    lfsr_q <= next_beat[DW+30:DW];
                    data_q <= next_beat[DW-1:0];
                    if (last_q) begin
                        beat_cnt_q <= '0;
                        frames_q   <= frames_q + CNT_W'(1);
                        last_q     <= (len_q == LEN_W'(1));
                    end else begin
                        beat_cnt_q <= beat_cnt_q + LEN_W'(1);
                        last_q     <= (beat_cnt_q + LEN_W'(1) == len_q - LEN_W'(1));
                    end
                end
                if (run_end) stop_pend_q <= 1'b0;
            end
        end
    end

endmodule
